// File: rtl/ram_clr.sv
// ram_clr: parametrised single-port RAM with a built-in clear sequencer.
// After reset, or on a clear request, every location is written with
// CLEAR_VAL, one word per cycle, while busy is high.
// Optional feature macro: RAM_CLR_REG_OUT_EN (registered read, 1-cycle latency).
module ram_clr #(
  parameter int unsigned       WIDTH     = 16,
  parameter int unsigned       ADDR_W    = 12,
  parameter logic [WIDTH-1:0]  CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_LOC = '1;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [WIDTH-1:0]    wdata;
  logic [WIDTH-1:0]    mem_q [DEPTH];

  assign busy = (state_q == CLEAR);

  // State and clear-counter registers; reset restarts the sweep from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and write-port selection: sweep owns the port while clearing,
  // and in IDLE a clear request takes priority over a user write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    waddr   = address;
    wdata   = in;
    case (state_q)
      CLEAR: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = CLEAR_VAL;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_LOC) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (load) begin
          we = 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Memory array: not reset, contents defined only once swept.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

`ifdef RAM_CLR_REG_OUT_EN
  logic [WIDTH-1:0] out_q;

  // Registered read port; old data is returned on a same-address write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= CLEAR_VAL;
    end else begin
      out_q <= busy ? CLEAR_VAL : mem_q[address];
    end
  end

  assign out = out_q;
`else
  assign out = busy ? CLEAR_VAL : mem_q[address];
`endif

endmodule

// File: tb/tb_ram_clr.sv
// tb_ram_clr: directed bench for ram_clr, default 16x4K instance plus a
// small 8-bit x 8 instance with a non-zero clear value.
module tb_ram_clr;

  logic        clk;
  logic        rst_n;

  logic [15:0] in16;
  logic        load16;
  logic [11:0] addr16;
  logic        clear16;
  logic [15:0] out16;
  logic        busy16;

  logic [7:0]  in8;
  logic        load8;
  logic [2:0]  addr8;
  logic        clear8;
  logic [7:0]  out8;
  logic        busy8;

  int          checks;
  int          errors;
  int          bad_busy_out;
  logic [15:0] sb_q [$];

  ram_clr dut16 (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in16),
    .load    (load16),
    .address (addr16),
    .clear   (clear16),
    .out     (out16),
    .busy    (busy16)
  );

  ram_clr #(
    .WIDTH     (8),
    .ADDR_W    (3),
    .CLEAR_VAL (8'hA5)
  ) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in8),
    .load    (load8),
    .address (addr8),
    .clear   (clear8),
    .out     (out8),
    .busy    (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Tasks start and end just after a rising edge.
  task automatic wr16(input logic [11:0] a, input logic [15:0] d);
    addr16 = a; in16 = d; load16 = 1'b1;
    @(posedge clk); #1;
    load16 = 1'b0;
  endtask

  task automatic wr8(input logic [2:0] a, input logic [7:0] d);
    addr8 = a; in8 = d; load8 = 1'b1;
    @(posedge clk); #1;
    load8 = 1'b0;
  endtask

  task automatic rd16(input string tag, input logic [11:0] a, input logic [15:0] exp);
    addr16 = a;
    sb_q.push_back(exp);
`ifdef RAM_CLR_REG_OUT_EN
    @(posedge clk); #1;
`endif
    @(negedge clk);
    chk(tag, out16, sb_q.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic rd8(input string tag, input logic [2:0] a, input logic [7:0] exp);
    addr8 = a;
    sb_q.push_back({8'h00, exp});
`ifdef RAM_CLR_REG_OUT_EN
    @(posedge clk); #1;
`endif
    @(negedge clk);
    chk(tag, {8'h00, out8}, sb_q.pop_front());
    @(posedge clk); #1;
  endtask

  // Counts busy cycles of the 16-bit instance, pokes a load mid-sweep and
  // watches that out stays at the clear value; abort_at>0 stops early.
  task automatic sweep(input int abort_at, output int n);
    n = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (!busy16) break;
      n++;
`ifdef RAM_CLR_REG_OUT_EN
      if (n > 1 && out16 !== 16'h0000) bad_busy_out++;
`else
      if (out16 !== 16'h0000) bad_busy_out++;
`endif
      if (n == 100) begin
        load16 = 1'b1; addr16 = 12'h001; in16 = 16'hFFFF;
      end
      if (n == 101) begin
        load16 = 1'b0; addr16 = 12'h123;
      end
      if (n == abort_at) break;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n16;
    int n8;
    int n;
    checks = 0; errors = 0; bad_busy_out = 0;
    rst_n = 1'b0;
    in16 = '0; load16 = 1'b0; addr16 = 12'h000; clear16 = 1'b0;
    in8 = '0; load8 = 1'b0; addr8 = 3'd0; clear8 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy16", {15'h0, busy16}, 16'h0001);
    chk("rst_out16", out16, 16'h0000);
    chk("rst_busy8", {15'h0, busy8}, 16'h0001);
    chk("rst_out8", {8'h00, out8}, 16'h00A5);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Power-up sweep for both instances
    n16 = 0; n8 = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (!busy16 && !busy8) break;
      if (busy16) n16++;
      if (busy8) n8++;
      if (busy16 && out16 !== 16'h0000) bad_busy_out++;
      if (busy8 && out8 !== 8'hA5) bad_busy_out++;
    end
    @(posedge clk); #1;
    chk("init_busy_len16", n16[15:0], 16'd4096);
    chk("init_busy_len8", n8[15:0], 16'd8);
    chk("init_out_during_busy", bad_busy_out[15:0], 16'd0);
    rd16("init_rd_abc", 12'hABC, 16'h0000);

    // Write then read back
    wr16(12'h005, 16'hBEEF);
    rd16("rd_005", 12'h005, 16'hBEEF);
    rd16("rd_006", 12'h006, 16'h0000);

    // Small instance: every location holds the clear value, then write/read
    for (int a = 0; a < 8; a++) begin
      logic [2:0] a3;
      a3 = a[2:0];
      rd8("rd8_clearval", a3, 8'hA5);
    end
    wr8(3'd7, 8'h3C);
    rd8("rd8_addr7", 3'd7, 8'h3C);

    // Clear request with load pulses ignored during the sweep
    wr16(12'h123, 16'h1234);
    rd16("rd_123_pre", 12'h123, 16'h1234);
    wr16(12'hFFF, 16'hCAFE);
    clear16 = 1'b1;
    @(negedge clk);
    chk("busy_before_accept", {15'h0, busy16}, 16'h0000);
    @(posedge clk); #1;
    clear16 = 1'b0;
    bad_busy_out = 0;
    sweep(0, n);
    chk("clear_busy_len", n[15:0], 16'd4096);
    chk("clear_out_during_busy", bad_busy_out[15:0], 16'd0);
    rd16("rd_123_post", 12'h123, 16'h0000);
    rd16("rd_001_noload", 12'h001, 16'h0000);
    rd16("rd_fff_post", 12'hFFF, 16'h0000);

    // Simultaneous load and clear: clear wins
    addr16 = 12'h010; in16 = 16'h5555; load16 = 1'b1; clear16 = 1'b1;
    @(posedge clk); #1;
    load16 = 1'b0; clear16 = 1'b0;
    sweep(0, n);
    chk("ldclr_busy_len", n[15:0], 16'd4096);
    rd16("rd_010_post", 12'h010, 16'h0000);

    // Reset in the middle of a sweep restarts it
    wr16(12'hFFF, 16'hCAFE);
    rd16("rd_fff_pre", 12'hFFF, 16'hCAFE);
    clear16 = 1'b1;
    @(posedge clk); #1;
    clear16 = 1'b0;
    sweep(2000, n);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {15'h0, busy16}, 16'h0001);
    chk("midrst_out", out16, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad_busy_out = 0;
    sweep(0, n);
    chk("midrst_busy_len", n[15:0], 16'd4096);
    chk("midrst_out_during_busy", bad_busy_out[15:0], 16'd0);
    rd16("rd_fff_midrst", 12'hFFF, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
